// File: rtl/ld3320_pkg.sv
// rtl/ld3320_pkg.sv - shared states, timing defaults and pin decode for the LD3320 bus controller
package ld3320_pkg;

  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_STROBE  = 4;
  localparam int unsigned DEF_T_HOLD    = 2;
  localparam int unsigned DEF_T_RST_LOW = 1000;
  localparam int unsigned DEF_T_RST_WAIT = 2000;
  localparam int          TIMER_W       = 16;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    RST_LOW,
    RST_WAIT
  } state_t;

  typedef struct packed {
    logic       rst_n;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] data_o;
    logic       data_oe;
  } pins_t;

  localparam pins_t PINS_IDLE = '{
    rst_n: 1'b1, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1,
    a0: 1'b0, data_o: 8'h00, data_oe: 1'b0
  };

  // Chip pin levels for the state being entered; registered by the caller.
  function automatic pins_t pins_for(state_t s, logic wr, logic [7:0] addr, logic [7:0] wdata);
    pins_t p;
    p = PINS_IDLE;
    case (s)
      ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
        p.cs_n    = 1'b0;
        p.a0      = 1'b1;
        p.data_o  = addr;
        p.data_oe = 1'b1;
        p.wr_n    = (s != ADDR_STROBE);
      end
      DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
        p.cs_n    = 1'b0;
        p.data_o  = wdata;
        p.data_oe = wr;
        if (s == DATA_STROBE) begin
          p.wr_n = !wr;
          p.rd_n = wr;
        end
      end
      RST_LOW:  p.rst_n = 1'b0;
      default:  p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ld3320_bus_ctrl_if.sv
// rtl/ld3320_bus_ctrl_if.sv - host request and LD3320 chip pin bundle
interface ld3320_bus_ctrl_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       done;
  logic [7:0] rdata;
  logic       chip_rst;
  logic       rst_busy;

  logic       ld_rst_n;
  logic       ld_cs_n;
  logic       ld_wr_n;
  logic       ld_rd_n;
  logic       ld_a0;
  logic [7:0] ld_data_o;
  logic       ld_data_oe;
  logic [7:0] ld_data_i;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, chip_rst, ld_data_i,
    input  req_ready, done, rdata, rst_busy,
    input  ld_rst_n, ld_cs_n, ld_wr_n, ld_rd_n, ld_a0, ld_data_o, ld_data_oe
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, chip_rst, ld_data_i,
    output req_ready, done, rdata, rst_busy,
    output ld_rst_n, ld_cs_n, ld_wr_n, ld_rd_n, ld_a0, ld_data_o, ld_data_oe
  );

endinterface

// File: rtl/ld3320_phase_timer.sv
// rtl/ld3320_phase_timer.sv - shared down counter timing every controller phase
module ld3320_phase_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_count;
  logic         r_active;

  // Loading value-1 makes o_expire assert in the last of i_value cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_count  <= i_value - 1'b1;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_expire = r_active && (r_count == '0);

endmodule

// File: rtl/ld3320_bus_ctrl.sv
// rtl/ld3320_bus_ctrl.sv - LD3320 parallel register access and chip reset sequencer
module ld3320_bus_ctrl
  import ld3320_pkg::*;
#(
  parameter int unsigned T_SETUP    = DEF_T_SETUP,
  parameter int unsigned T_STROBE   = DEF_T_STROBE,
  parameter int unsigned T_HOLD     = DEF_T_HOLD,
  parameter int unsigned T_RST_LOW  = DEF_T_RST_LOW,
  parameter int unsigned T_RST_WAIT = DEF_T_RST_WAIT
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  ld3320_bus_ctrl_if.slave   bus
);

  localparam logic [TIMER_W-1:0] C_SETUP    = TIMER_W'(T_SETUP);
  localparam logic [TIMER_W-1:0] C_STROBE   = TIMER_W'(T_STROBE);
  localparam logic [TIMER_W-1:0] C_HOLD     = TIMER_W'(T_HOLD);
  localparam logic [TIMER_W-1:0] C_RST_LOW  = TIMER_W'(T_RST_LOW);
  localparam logic [TIMER_W-1:0] C_RST_WAIT = TIMER_W'(T_RST_WAIT);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_tmr_start;
  logic [TIMER_W-1:0]   w_tmr_value;
  logic                 w_tmr_expire;
  logic                 w_accept;

  logic                 r_write;
  logic [7:0]           r_addr;
  logic [7:0]           r_wdata;
  logic                 w_write;
  logic [7:0]           w_addr;
  logic [7:0]           w_wdata;

  logic                 r_req_ready;
  logic                 r_done;
  logic [7:0]           r_rdata;
  logic                 r_rst_busy;
  pins_t                r_pins;

  ld3320_phase_timer #(.W(TIMER_W)) u_timer (
    .i_clk    (ACLK),
    .i_rst_n  (ARESETN),
    .i_start  (w_tmr_start),
    .i_value  (w_tmr_value),
    .o_expire (w_tmr_expire)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // r_req_ready gates IDLE so the first cycle after reset release takes nothing.
  always_comb begin
    w_next_state = r_state;
    w_tmr_start  = 1'b0;
    w_tmr_value  = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req_ready && bus.chip_rst) begin
          w_next_state = RST_LOW;
          w_tmr_start  = 1'b1;
          w_tmr_value  = C_RST_LOW;
        end else if (r_req_ready && bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = ADDR_SETUP;
          w_tmr_start  = 1'b1;
          w_tmr_value  = C_SETUP;
        end
      end
      ADDR_SETUP, DATA_SETUP: begin
        if (w_tmr_expire) begin
          w_next_state = (r_state == ADDR_SETUP) ? ADDR_STROBE : DATA_STROBE;
          w_tmr_start  = 1'b1;
          w_tmr_value  = C_STROBE;
        end
      end
      ADDR_STROBE, DATA_STROBE: begin
        if (w_tmr_expire) begin
          w_next_state = (r_state == ADDR_STROBE) ? ADDR_HOLD : DATA_HOLD;
          w_tmr_start  = 1'b1;
          w_tmr_value  = C_HOLD;
        end
      end
      ADDR_HOLD: begin
        if (w_tmr_expire) begin
          w_next_state = DATA_SETUP;
          w_tmr_start  = 1'b1;
          w_tmr_value  = C_SETUP;
        end
      end
      DATA_HOLD: begin
        if (w_tmr_expire) w_next_state = IDLE;
      end
      RST_LOW: begin
        if (w_tmr_expire) begin
          w_next_state = RST_WAIT;
          w_tmr_start  = 1'b1;
          w_tmr_value  = C_RST_WAIT;
        end
      end
      RST_WAIT: begin
        if (w_tmr_expire) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_write = w_accept ? bus.req_write : r_write;
  assign w_addr  = w_accept ? bus.req_addr  : r_addr;
  assign w_wdata = w_accept ? bus.req_wdata : r_wdata;

  // Outputs are decoded from the next state so pins move on the transition edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_req_ready <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= 8'h00;
      r_rst_busy  <= 1'b0;
      r_pins      <= PINS_IDLE;
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      r_req_ready <= (w_next_state == IDLE);
      r_done      <= (r_state == DATA_HOLD) && w_tmr_expire;
      r_rst_busy  <= (w_next_state == RST_LOW) || (w_next_state == RST_WAIT);
      r_pins      <= pins_for(w_next_state, w_write, w_addr, w_wdata);
      if ((r_state == DATA_STROBE) && w_tmr_expire && !r_write) begin
        r_rdata <= bus.ld_data_i;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.done       = r_done;
  assign bus.rdata      = r_rdata;
  assign bus.rst_busy   = r_rst_busy;
  assign bus.ld_rst_n   = r_pins.rst_n;
  assign bus.ld_cs_n    = r_pins.cs_n;
  assign bus.ld_wr_n    = r_pins.wr_n;
  assign bus.ld_rd_n    = r_pins.rd_n;
  assign bus.ld_a0      = r_pins.a0;
  assign bus.ld_data_o  = r_pins.data_o;
  assign bus.ld_data_oe = r_pins.data_oe;

endmodule

// File: tb/tb_ld3320_bus_ctrl.sv
// tb/tb_ld3320_bus_ctrl.sv - directed bench with a cycle model of the LD3320 bus controller
module tb_ld3320_bus_ctrl;

  localparam int TS = 2;
  localparam int TB = 4;
  localparam int TH = 2;
  localparam int RL = 10;
  localparam int RW = 20;
  localparam int P  = TS + TB + TH;

  // {ready, done, rdata, rst_busy, rst_n, cs_n, wr_n, rd_n, a0, data_o, data_oe}
  localparam logic [24:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ld3320_bus_ctrl_if bus();

  ld3320_bus_ctrl #(
    .T_SETUP(TS), .T_STROBE(TB), .T_HOLD(TH), .T_RST_LOW(RL), .T_RST_WAIT(RW)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef enum {M_RESET, M_IDLE, M_XFER, M_CHIPRST} mmode_t;
  mmode_t     m_mode  = M_RESET;
  int         m_k     = 0;
  logic       m_done  = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_write = 1'b0;
  logic [7:0] m_addr  = 8'h00;
  logic [7:0] m_wdata = 8'h00;

  function automatic logic [24:0] model_vec();
    logic rst_n, cs_n, wr_n, rd_n, a0, oe, addr_half, strobe;
    logic [7:0] dat;
    int j;
    rst_n = !(m_mode == M_CHIPRST && m_k <= RL);
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0; oe = 1'b0; dat = 8'h00;
    if (m_mode == M_XFER) begin
      addr_half = (m_k <= P);
      j         = (m_k - 1) % P;
      strobe    = (j >= TS) && (j < TS + TB);
      cs_n      = 1'b0;
      a0        = addr_half;
      dat       = addr_half ? m_addr : m_wdata;
      oe        = addr_half || m_write;
      wr_n      = !(strobe && (addr_half || m_write));
      rd_n      = !(strobe && !addr_half && !m_write);
    end
    return {m_mode == M_IDLE, m_done, m_rdata, m_mode == M_CHIPRST, rst_n, cs_n, wr_n, rd_n, a0, dat, oe};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.req_ready, bus.done, bus.rdata, bus.rst_busy, bus.ld_rst_n, bus.ld_cs_n,
            bus.ld_wr_n, bus.ld_rd_n, bus.ld_a0, bus.ld_data_o, bus.ld_data_oe};
  endfunction

  // Model: k counts cycles since the accepting edge; phases follow from arithmetic on k.
  initial forever begin
    @(posedge ACLK or negedge ARESETN);
    if (!ARESETN) begin
      m_mode = M_RESET; m_k = 0; m_done = 1'b0; m_rdata = 8'h00;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        M_RESET: m_mode = M_IDLE;
        M_IDLE: begin
          if (bus.chip_rst) begin
            m_mode = M_CHIPRST; m_k = 1;
          end else if (bus.req_valid) begin
            m_mode = M_XFER; m_k = 1;
            m_write = bus.req_write; m_addr = bus.req_addr; m_wdata = bus.req_wdata;
          end
        end
        M_XFER: begin
          if (!m_write && m_k > P && (m_k - 1) % P == TS + TB - 1) m_rdata = bus.ld_data_i;
          if (m_k == 2 * P) begin
            m_mode = M_IDLE; m_done = 1'b1;
          end else begin
            m_k++;
          end
        end
        M_CHIPRST: begin
          if (m_k == RL + RW) m_mode = M_IDLE;
          else m_k++;
        end
        default: m_mode = M_RESET;
      endcase
    end
  end

  initial forever begin
    @(negedge ACLK);
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, dut_vec(), model_vec());
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [63:0] v_cs_n, v_wr_n, v_rd_n, v_a0, v_oe, v_done, v_ready, v_rst_n, v_busy;
  logic [7:0]  s_data [64];
  logic [7:0]  s_rdata[64];

  function automatic int cnt(input logic [63:0] v, input int lo, input int hi, input logic val);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (v[i] === val) n++;
    return n;
  endfunction

  function automatic int first(input logic [63:0] v, input int lo, input int hi, input logic val);
    for (int i = lo; i <= hi; i++) if (v[i] === val) return i;
    return -1;
  endfunction

  function automatic int falls(input logic [63:0] v, input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (v[i-1] === 1'b1 && v[i] === 1'b0) n++;
    return n;
  endfunction

  task automatic wait_accept(output int ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (bus.req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(posedge ACLK); #1;
  endtask

  // Called just after an edge; cycle 1 is the cycle following that edge.
  task automatic record(input int n, input int drop_at, input int d_lo, input int d_hi, input logic [7:0] dval);
    v_cs_n = '0; v_wr_n = '0; v_rd_n = '0; v_a0 = '0; v_oe = '0;
    v_done = '0; v_ready = '0; v_rst_n = '0; v_busy = '0;
    v_cs_n[0] = 1'b1; v_wr_n[0] = 1'b1; v_rd_n[0] = 1'b1; v_rst_n[0] = 1'b1;
    for (int c = 1; c <= n; c++) begin
      if (c == drop_at) bus.req_valid = 1'b0;
      bus.ld_data_i = (c >= d_lo && c <= d_hi) ? dval : 8'hFF;
      @(negedge ACLK);
      v_cs_n[c] = bus.ld_cs_n;  v_wr_n[c] = bus.ld_wr_n;  v_rd_n[c] = bus.ld_rd_n;
      v_a0[c]   = bus.ld_a0;    v_oe[c]   = bus.ld_data_oe; v_done[c] = bus.done;
      v_ready[c] = bus.req_ready; v_rst_n[c] = bus.ld_rst_n; v_busy[c] = bus.rst_busy;
      s_data[c] = bus.ld_data_o; s_rdata[c] = bus.rdata;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic set_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int ok;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    bus.chip_rst = 1'b0; bus.ld_data_i = 8'hFF;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_vec("reset_pins", dut_vec(), RESET_VEC);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    check("ready_after_release", int'(bus.req_ready), 1);
    @(posedge ACLK); #1;

    // Write 0xB7 <- 0x22
    set_req(1'b1, 8'hB7, 8'h22);
    wait_accept(ok); check("wr_accept", ok, 1);
    record(20, 1, 0, 0, 8'h00);
    check("wr_done_cycle", first(v_done, 1, 20, 1'b1), 17);
    check("wr_done_count", cnt(v_done, 1, 20, 1'b1), 1);
    check("wr_wr_low_cycles", cnt(v_wr_n, 1, 20, 1'b0), 8);
    check("wr_wr_pulses", falls(v_wr_n, 1, 20), 2);
    check("wr_a0_high_cycles", cnt(v_a0, 1, 20, 1'b1), 8);
    check("wr_addr_on_bus", int'(s_data[1]), 8'hB7);
    check("wr_data_on_bus", int'(s_data[9]), 8'h22);
    check("wr_rd_low_cycles", cnt(v_rd_n, 1, 20, 1'b0), 0);

    // Read 0x06, chip returns 0x5A during the data strobe
    set_req(1'b0, 8'h06, 8'h99);
    wait_accept(ok); check("rd_accept", ok, 1);
    record(20, 1, 11, 14, 8'h5A);
    check("rd_wr_pulses", falls(v_wr_n, 1, 20), 1);
    check("rd_rd_pulses", falls(v_rd_n, 1, 20), 1);
    check("rd_rd_low_cycles", cnt(v_rd_n, 11, 14, 1'b0), 4);
    check("rd_oe_during_strobe", cnt(v_oe, 11, 14, 1'b1), 0);
    check("rd_rdata_before_capture", int'(s_rdata[14]), 8'h00);
    check("rd_rdata_at_done", int'(s_rdata[17]), 8'h5A);
    check("rd_done_cycle", first(v_done, 1, 20, 1'b1), 17);

    // Back-to-back: valid held, second request (read 0x10) waits in the port
    set_req(1'b1, 8'hA1, 8'h3C);
    wait_accept(ok); check("b2b_accept", ok, 1);
    set_req(1'b0, 8'h10, 8'h00);
    record(36, 18, 28, 31, 8'hC3);
    check("b2b_done_count", cnt(v_done, 1, 36, 1'b1), 2);
    check("b2b_first_done", first(v_done, 1, 36, 1'b1), 17);
    check("b2b_second_done", int'(v_done[34]), 1);
    check("b2b_ready_in_done", int'(v_ready[17]), 1);
    check("b2b_cs_gap", cnt(v_cs_n, 1, 33, 1'b1), 1);
    check("b2b_rdata", int'(s_rdata[34]), 8'hC3);

    // chip_rst and req_valid together in IDLE
    bus.chip_rst = 1'b1;
    set_req(1'b1, 8'h55, 8'h66);
    @(posedge ACLK); #1;
    bus.chip_rst = 1'b0;
    record(50, 32, 0, 0, 8'h00);
    check("crst_rst_low_cycles", cnt(v_rst_n, 1, 50, 1'b0), 10);
    check("crst_rst_low_first", first(v_rst_n, 1, 50, 1'b0), 1);
    check("crst_busy_cycles", cnt(v_busy, 1, 50, 1'b1), 30);
    check("crst_ready_first", first(v_ready, 1, 50, 1'b1), 31);
    check("crst_cs_first_low", first(v_cs_n, 1, 50, 1'b0), 32);
    check("crst_done_cycle", first(v_done, 1, 50, 1'b1), 48);

    // ARESETN during the data strobe of a write
    set_req(1'b1, 8'h3A, 8'h7E);
    wait_accept(ok); check("abort_accept", ok, 1);
    record(12, 1, 0, 0, 8'h00);
    check("abort_in_strobe", int'(v_wr_n[12]), 0);
    ARESETN = 1'b0;
    #1;
    check_vec("abort_pins", dut_vec(), RESET_VEC);
    @(posedge ACLK); @(negedge ACLK);
    check("abort_no_done", int'(bus.done), 0);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    set_req(1'b1, 8'h01, 8'h02);
    wait_accept(ok); check("post_abort_accept", ok, 1);
    record(20, 1, 0, 0, 8'h00);
    check("post_abort_done", first(v_done, 1, 20, 1'b1), 17);
    check("post_abort_addr", int'(s_data[1]), 8'h01);
    check("post_abort_data", int'(s_data[9]), 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
